// File: rtl/adam_pause_seq_pkg.sv
// Shared types for the ADAM pause/resume sequencer: FSM state encoding and
// the index-width helper used to size the per-instance channel index type.
package adam_pause_seq_pkg;

   typedef enum logic [2:0] {
      RUNNING,
      PAUSING,
      PAUSED,
      RESUMING,
      SETTLE
   } state_t;

   // Channel index width; a single channel still needs one index bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/adam_pause_seq_tmo.sv
// Load/increment saturating cycle counter; expired flags the last cycle of a
// non-zero limit. Serves both the ack timeout and the settle delay.
module adam_pause_seq_tmo
   import adam_pause_seq_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         inc,
   input  logic [W-1:0] limit,
   output logic         expired
);

   logic [W-1:0] tmo_cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_reg <= '0;
      end else if (load) begin
         tmo_cnt_reg <= '0;
      end else if (inc && (tmo_cnt_reg != '1)) begin
         tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      end
   end

   // A zero limit never expires, which gives the wait-forever behaviour.
   assign expired = (limit != '0) && (tmo_cnt_reg == (limit - 1'b1));

endmodule

// File: rtl/adam_pause_seq.sv
// Pause/resume sequencer: pauses enabled channels in ascending order, resumes
// in descending order, with per-channel ack timeout and sticky error flags.
// Optional macro ADAM_PAUSE_SEQ_DELAY_EN adds a settle input and SETTLE state.
module adam_pause_seq
   import adam_pause_seq_pkg::*;
#(
   parameter int NO_CHANNELS = 4,
   parameter int TIMEOUT_W   = 16,
   parameter int RST_PAUSED  = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   pause_req,
   output logic                   pause_ack,
   input  logic [NO_CHANNELS-1:0] ch_en,
   input  logic [TIMEOUT_W-1:0]   timeout,
`ifdef ADAM_PAUSE_SEQ_DELAY_EN
   input  logic [TIMEOUT_W-1:0]   settle,
`endif
   output logic [NO_CHANNELS-1:0] ch_req,
   input  logic [NO_CHANNELS-1:0] ch_ack,
   output logic [NO_CHANNELS-1:0] err,
   input  logic                   err_clr,
   output logic                   busy
);

   localparam int IDX_W = idx_width(NO_CHANNELS);
   typedef logic [IDX_W-1:0] idx_t;
   localparam idx_t LAST_IDX = idx_t'(NO_CHANNELS - 1);

   state_t                 state_reg;
   idx_t                   idx_reg;
   logic                   wait_reg;
   logic [NO_CHANNELS-1:0] ch_req_reg;
   logic [NO_CHANNELS-1:0] err_reg;
   logic                   pause_ack_reg;
   logic                   busy_reg;
`ifdef ADAM_PAUSE_SEQ_DELAY_EN
   logic                   dir_reg;
   logic                   settle_go;
`endif

   logic                   in_step;
   logic                   ack_seen;
   logic                   tmo_hit;
   logic                   step_done;
   logic                   advance;
   logic                   pause_dir;
   logic                   tmo_expired;
   logic                   tmo_load;
   logic                   tmo_inc;
   logic [TIMEOUT_W-1:0]   tmo_limit;
   logic                   enter_step;
   logic                   enter_pause;
   idx_t                   enter_idx;
   logic                   go_paused;
   logic                   go_running;
   logic [NO_CHANNELS-1:0] err_set;

   adam_pause_seq_tmo #(
      .W (TIMEOUT_W)
   ) u_tmo (
      .clk     (clk),
      .rst     (rst),
      .load    (tmo_load),
      .inc     (tmo_inc),
      .limit   (tmo_limit),
      .expired (tmo_expired)
   );

   // Step completion: wait_reg records whether this step owns a handshake.
   always_comb begin
      in_step   = (state_reg == PAUSING) || (state_reg == RESUMING);
      ack_seen  = (state_reg == PAUSING) ? ch_ack[idx_reg] : ~ch_ack[idx_reg];
      tmo_hit   = in_step && wait_reg && !ack_seen && tmo_expired;
      step_done = in_step && (!wait_reg || ack_seen || tmo_hit);
`ifdef ADAM_PAUSE_SEQ_DELAY_EN
      settle_go = step_done && wait_reg && (settle != '0);
      advance   = (step_done && !settle_go) || ((state_reg == SETTLE) && tmo_expired);
      pause_dir = (state_reg == PAUSING) || ((state_reg == SETTLE) && dir_reg);
      tmo_limit = (state_reg == SETTLE) ? settle : timeout;
      tmo_inc   = (in_step && wait_reg) || (state_reg == SETTLE);
`else
      advance   = step_done;
      pause_dir = (state_reg == PAUSING);
      tmo_limit = timeout;
      tmo_inc   = in_step && wait_reg;
`endif
      tmo_load  = (state_reg == RUNNING) || (state_reg == PAUSED) || step_done || advance;
      err_set   = '0;
      if (tmo_hit) begin
         err_set[idx_reg] = 1'b1;
      end
   end

   // Next-step selection; pause_req is only looked at on channel boundaries.
   always_comb begin
      enter_step  = 1'b0;
      enter_pause = 1'b0;
      enter_idx   = idx_reg;
      go_paused   = 1'b0;
      go_running  = 1'b0;
      case (state_reg)
         RUNNING: begin
            if (pause_req) begin
               enter_step  = 1'b1;
               enter_pause = 1'b1;
               enter_idx   = '0;
            end
         end
         PAUSED: begin
            if (!pause_req) begin
               enter_step = 1'b1;
               enter_idx  = LAST_IDX;
            end
         end
         default: begin
            if (advance) begin
               if (pause_dir) begin
                  if (!pause_req) begin
                     enter_step = 1'b1;
                  end else if (idx_reg == LAST_IDX) begin
                     go_paused = 1'b1;
                  end else begin
                     enter_step  = 1'b1;
                     enter_pause = 1'b1;
                     enter_idx   = idx_reg + idx_t'(1);
                  end
               end else begin
                  if (pause_req) begin
                     enter_step  = 1'b1;
                     enter_pause = 1'b1;
                  end else if (idx_reg == '0) begin
                     go_running = 1'b1;
                  end else begin
                     enter_step = 1'b1;
                     enter_idx  = idx_reg - idx_t'(1);
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if (RST_PAUSED != 0) begin
            state_reg     <= PAUSED;
            idx_reg       <= LAST_IDX;
            ch_req_reg    <= '1;
            pause_ack_reg <= 1'b1;
         end else begin
            state_reg     <= RUNNING;
            idx_reg       <= '0;
            ch_req_reg    <= '0;
            pause_ack_reg <= 1'b0;
         end
         wait_reg <= 1'b0;
         err_reg  <= '0;
         busy_reg <= 1'b0;
`ifdef ADAM_PAUSE_SEQ_DELAY_EN
         dir_reg  <= 1'b0;
`endif
      end else begin
         // A timeout landing with err_clr still sets its own bit.
         err_reg <= (err_clr ? '0 : err_reg) | err_set;
         if (enter_step) begin
            idx_reg  <= enter_idx;
            busy_reg <= 1'b1;
            if (enter_pause) begin
               state_reg <= PAUSING;
               wait_reg  <= ch_en[enter_idx];
               if (ch_en[enter_idx]) begin
                  ch_req_reg[enter_idx] <= 1'b1;
               end
            end else begin
               // Release regardless of ch_en so a disabled-but-held channel drops.
               state_reg             <= RESUMING;
               wait_reg              <= ch_req_reg[enter_idx];
               ch_req_reg[enter_idx] <= 1'b0;
            end
         end else if (go_paused) begin
            state_reg     <= PAUSED;
            pause_ack_reg <= 1'b1;
            busy_reg      <= 1'b0;
            wait_reg      <= 1'b0;
         end else if (go_running) begin
            state_reg     <= RUNNING;
            pause_ack_reg <= 1'b0;
            busy_reg      <= 1'b0;
            wait_reg      <= 1'b0;
         end
`ifdef ADAM_PAUSE_SEQ_DELAY_EN
         else if (settle_go) begin
            state_reg <= SETTLE;
            dir_reg   <= (state_reg == PAUSING);
         end
`endif
      end
   end

   assign pause_ack = pause_ack_reg;
   assign ch_req    = ch_req_reg;
   assign err       = err_reg;
   assign busy      = busy_reg;

endmodule

// File: tb/tb_adam_pause_seq.sv
// Directed bench for adam_pause_seq (4 channels, reset into PAUSED): vector
// table for release/pause ordering plus hand sequences for timeouts and aborts.
module tb_adam_pause_seq;

   logic        clk;
   logic        rst;
   logic        pause_req;
   logic        pause_ack;
   logic [3:0]  ch_en;
   logic [15:0] timeout;
   logic [3:0]  ch_req;
   logic [3:0]  ch_ack;
   logic [3:0]  err;
   logic        err_clr;
   logic        busy;
`ifdef ADAM_PAUSE_SEQ_DELAY_EN
   logic [15:0] settle;
`endif

   // Downstream ack model: immediate or 2-cycle delayed, with per-bit hold-low.
   logic [3:0] d1, d2, force0, sel;
   int         dly;

   int n_tests = 0;
   int n_fail  = 0;

   adam_pause_seq #(
      .NO_CHANNELS (4),
      .TIMEOUT_W   (16),
      .RST_PAUSED  (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pause_req (pause_req),
      .pause_ack (pause_ack),
      .ch_en     (ch_en),
      .timeout   (timeout),
`ifdef ADAM_PAUSE_SEQ_DELAY_EN
      .settle    (settle),
`endif
      .ch_req    (ch_req),
      .ch_ack    (ch_ack),
      .err       (err),
      .err_clr   (err_clr),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      d1 <= ch_req;
      d2 <= d1;
   end

   always_comb begin
      sel    = (dly == 2) ? d2 : ch_req;
      ch_ack = sel & ~force0;
   end

   typedef struct {
      logic       pause_req;
      logic [3:0] ch_en;
      int         dly;
      logic [3:0] exp_req;
      logic       exp_ack;
      logic       exp_busy;
   } vec_t;

   vec_t vq[$];

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_ack(input logic exp, input int bound, input string name);
      int n = 0;
      while (pause_ack !== exp && n < bound) begin
         tick(1);
         n++;
      end
      chk(name, 32'(pause_ack), 32'(exp));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst       = 1'b1;
      pause_req = 1'b1;
      ch_en     = 4'b1111;
      timeout   = 16'd0;
      err_clr   = 1'b0;
      force0    = 4'b0000;
      dly       = 0;
`ifdef ADAM_PAUSE_SEQ_DELAY_EN
      settle    = 16'd0;
`endif
      tick(3);
      chk("rst_req_in_reset", 32'(ch_req), 32'h0000000f);
      rst = 1'b0;
      tick(1);
      chk("rst_req", 32'(ch_req), 32'h0000000f);
      chk("rst_ack", 32'(pause_ack), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      $display("[TB] reset: ch_req=%b pause_ack=%0b busy=%0b err=%b", ch_req, pause_ack, busy, err);

      // Release from reset-paused with immediate acks, then pause with ch2 off.
      vq.push_back('{1'b0, 4'b1111, 0, 4'b0111, 1'b1, 1'b1});
      vq.push_back('{1'b0, 4'b1111, 0, 4'b0011, 1'b1, 1'b1});
      vq.push_back('{1'b0, 4'b1111, 0, 4'b0001, 1'b1, 1'b1});
      vq.push_back('{1'b0, 4'b1111, 0, 4'b0000, 1'b1, 1'b1});
      vq.push_back('{1'b0, 4'b1111, 0, 4'b0000, 1'b0, 1'b0});
      vq.push_back('{1'b0, 4'b1111, 0, 4'b0000, 1'b0, 1'b0});
      vq.push_back('{1'b1, 4'b1011, 2, 4'b0001, 1'b0, 1'b1});
      vq.push_back('{1'b1, 4'b1011, 2, 4'b0001, 1'b0, 1'b1});
      vq.push_back('{1'b1, 4'b1011, 2, 4'b0001, 1'b0, 1'b1});
      vq.push_back('{1'b1, 4'b1011, 2, 4'b0011, 1'b0, 1'b1});
      vq.push_back('{1'b1, 4'b1011, 2, 4'b0011, 1'b0, 1'b1});
      vq.push_back('{1'b1, 4'b1011, 2, 4'b0011, 1'b0, 1'b1});
      vq.push_back('{1'b1, 4'b1011, 2, 4'b0011, 1'b0, 1'b1});
      vq.push_back('{1'b1, 4'b1011, 2, 4'b1011, 1'b0, 1'b1});
      vq.push_back('{1'b1, 4'b1011, 2, 4'b1011, 1'b0, 1'b1});
      vq.push_back('{1'b1, 4'b1011, 2, 4'b1011, 1'b0, 1'b1});
      vq.push_back('{1'b1, 4'b1011, 2, 4'b1011, 1'b1, 1'b0});

      for (int i = 0; i < vq.size(); i++) begin
         pause_req = vq[i].pause_req;
         ch_en     = vq[i].ch_en;
         dly       = vq[i].dly;
         tick(1);
         $display("[TB] vec %0d: pause_req=%0b ch_en=%b ch_req=%b pause_ack=%0b busy=%0b",
                  i, pause_req, ch_en, ch_req, pause_ack, busy);
         chk($sformatf("vec%0d_req", i), 32'(ch_req), 32'(vq[i].exp_req));
         chk($sformatf("vec%0d_ack", i), 32'(pause_ack), 32'(vq[i].exp_ack));
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vq[i].exp_busy));
      end

      dly       = 0;
      pause_req = 1'b0;
      wait_ack(1'b0, 20, "release_1011");
      chk("release_1011_req", 32'(ch_req), 32'd0);
      $display("[TB] release after 1011 pause: ch_req=%b pause_ack=%0b", ch_req, pause_ack);

      // Timeout on channel 1 (ack stuck low), timeout=10.
      ch_en     = 4'b1111;
      timeout   = 16'd10;
      force0    = 4'b0010;
      pause_req = 1'b1;
      tick(11);
      chk("tmo_err_before", 32'(err), 32'd0);
      chk("tmo_req_waiting", 32'(ch_req), 32'h3);
      tick(1);
      chk("tmo_err_set", 32'(err), 32'h2);
      chk("tmo_busy", 32'(busy), 32'd1);
      tick(2);
      chk("tmo_paused_ack", 32'(pause_ack), 32'd1);
      chk("tmo_paused_req", 32'(ch_req), 32'hf);
      $display("[TB] timeout: err=%b ch_req=%b pause_ack=%0b", err, ch_req, pause_ack);
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      chk("err_clr", 32'(err), 32'd0);
      $display("[TB] err_clr: err=%b", err);
      force0    = 4'b0000;
      pause_req = 1'b0;
      wait_ack(1'b0, 30, "tmo_release");
      chk("tmo_release_req", 32'(ch_req), 32'd0);

      // pause_req drops while channel 2 is still waiting for its ack.
      timeout   = 16'd0;
      force0    = 4'b0100;
      pause_req = 1'b1;
      tick(3);
      chk("abort_wait_req", 32'(ch_req), 32'h7);
      pause_req = 1'b0;
      tick(3);
      chk("abort_hold_req", 32'(ch_req), 32'h7);
      chk("abort_hold_busy", 32'(busy), 32'd1);
      force0 = 4'b0000;
      tick(1);
      chk("abort_rel2", 32'(ch_req), 32'h3);
      tick(1);
      chk("abort_rel1", 32'(ch_req), 32'h1);
      tick(1);
      chk("abort_rel0", 32'(ch_req), 32'h0);
      chk("abort_rel0_busy", 32'(busy), 32'd1);
      tick(1);
      chk("abort_done_busy", 32'(busy), 32'd0);
      chk("abort_done_ack", 32'(pause_ack), 32'd0);
      $display("[TB] abort: ch_req=%b pause_ack=%0b busy=%0b", ch_req, pause_ack, busy);

      // timeout=0 never expires; ack withheld on channel 0 for 1000 cycles.
      force0    = 4'b0001;
      pause_req = 1'b1;
      tick(1);
      begin
         int bad = 0;
         for (int i = 0; i < 1000; i++) begin
            tick(1);
            if (busy !== 1'b1 || err !== 4'b0000 || ch_req !== 4'b0001) bad++;
         end
         chk("nowait_bad_cycles", 32'(bad), 32'd0);
      end
      force0 = 4'b0000;
      tick(1);
      chk("nowait_advance", 32'(ch_req), 32'h3);
      wait_ack(1'b1, 20, "nowait_paused");
      chk("nowait_err", 32'(err), 32'd0);
      $display("[TB] wait-forever: ch_req=%b pause_ack=%0b err=%b", ch_req, pause_ack, err);

`ifdef ADAM_PAUSE_SEQ_DELAY_EN
      pause_req = 1'b0;
      wait_ack(1'b0, 30, "settle_pre_release");
      settle    = 16'd3;
      pause_req = 1'b1;
      tick(1);
      chk("settle_req0", 32'(ch_req), 32'h1);
      tick(3);
      chk("settle_hold", 32'(ch_req), 32'h1);
      chk("settle_busy", 32'(busy), 32'd1);
      tick(1);
      chk("settle_req1", 32'(ch_req), 32'h3);
      $display("[TB] settle=3: ch_req=%b", ch_req);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/adam_pause_seq.md
Name: adam_pause_seq

Overview:
- Parametrised pause/resume sequencer for N downstream pause channels behind one upstream ADAM pause slave port.
- Generalises the fixed per-domain pause fan-out done at SoC top level.
- Pauses enabled channels one at a time in ascending index order, and resumes them in descending order.
- Per-channel timeout with sticky error flags; used by syscfg to order fabric, peripheral and CPU pausing within a domain.

Parameters:
- NO_CHANNELS, 4, number of downstream pause channels (1..32).
- TIMEOUT_W, 16, width of the ack timeout counter and of the timeout input.
- RST_PAUSED, 1, 1 = come out of reset in PAUSED with all ch_req high; 0 = come out of reset in RUNNING with all ch_req low.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- pause_req  in  1  upstream pause request.
- pause_ack  out  1  upstream pause acknowledge.
- ch_en  in  NO_CHANNELS  per-channel participate mask, sampled at each channel step.
- timeout  in  TIMEOUT_W  cycles to wait for an ack transition; 0 = wait forever.
- ch_req  out  NO_CHANNELS  downstream pause requests.
- ch_ack  in  NO_CHANNELS  downstream pause acknowledges.
- err  out  NO_CHANNELS  sticky per-channel timeout flags.
- err_clr  in  1  single-cycle pulse that clears all err bits.
- busy  out  1  high while in PAUSING or RESUMING.

Behaviour:
- Reset values:
  - RST_PAUSED=1: state PAUSED, ch_req all ones, pause_ack=1, idx=NO_CHANNELS-1.
  - RST_PAUSED=0: state RUNNING, ch_req all zero, pause_ack=0, idx=0.
  - Both cases: err=0, busy=0, tmo_cnt=0.
- Handshake: 4-phase on every channel.
  - Pausing: raise req, wait for ack=1.
  - Resuming: drop req, wait for ack=0.
  - Upstream follows the same 4-phase rule.
- RUNNING:
  - pause_ack=0.
  - On pause_req=1, go to PAUSING with idx=0.
- PAUSING:
  - If ch_en[idx]=0: skip; ch_req[idx] stays 0; advance next cycle.
  - Otherwise ch_req[idx]=1, and the block waits until ch_ack[idx]=1 or tmo_cnt reaches timeout-1.
    - ack: advance.
    - timeout: set err[idx], keep ch_req[idx]=1, advance.
  - Advance: if idx=NO_CHANNELS-1, go to PAUSED; else idx+1 and tmo_cnt=0.
  - Minimum latency is 1 cycle per channel, so pause_ack rises no earlier than NO_CHANNELS+1 cycles after pause_req.
- PAUSED:
  - pause_ack=1.
  - On pause_req=0, go to RESUMING with idx=NO_CHANNELS-1.
- RESUMING:
  - Mirror of PAUSING, with descending idx.
  - For each channel whose ch_req[idx]=1: drop it and wait for ch_ack[idx]=0 or timeout (timeout sets err[idx]).
  - Channels already low advance in 1 cycle.
  - After idx=0, go to RUNNING and drop pause_ack.
- Upstream change mid-sequence:
  - A pause_req change is evaluated only at channel boundaries; the current channel handshake always completes first.
  - pause_req=0 during PAUSING: switch to RESUMING starting at the current idx.
  - pause_req=1 during RESUMING: switch to PAUSING starting at the current idx.
- ch_en change mid-sequence takes effect at the next step of the affected channel.
  - A channel disabled while its req is high is still released during RESUMING.
- err_clr in the same cycle as a new timeout: the set wins for that bit, and other bits clear.
- Timeout counter:
  - tmo_cnt saturates at all-ones.
  - It resets on every channel advance.
  - timeout=0 disables the timeout check.
- busy is registered and follows the state.

Optional Feature:
- Macro: ADAM_PAUSE_SEQ_DELAY_EN.
- When defined:
  - Adds input settle (width TIMEOUT_W).
  - After each enabled channel completes (ack or timeout), the FSM sits in SETTLE for settle cycles before advancing.
  - settle=0 means no extra cycle.
- When undefined: no port, no SETTLE state; advance happens the cycle after completion.

Decomposition:
- Package adam_pause_seq_pkg holds:
  - state_t enum {RUNNING, PAUSING, PAUSED, RESUMING, SETTLE}.
  - typedef idx_t sized $clog2(NO_CHANNELS) (minimum 1 bit).
- One sub-module, adam_pause_seq_tmo: a load/enable/saturating timeout counter with an expired output, reused for the settle delay.

Test Plan:
- Reset with RST_PAUSED=1, NO_CHANNELS=4 -> ch_req=4'b1111, pause_ack=1; pause_req=0 with immediate acks -> ch_req falls in order 3,2,1,0, and pause_ack=0 exactly 5 cycles later.
- RUNNING, ch_en=4'b1011, acks 2 cycles after req -> pause order 0,1,3, ch_req[2] never rises, pause_ack=1 after all three acks.
- timeout=10, ch_ack[1] stuck 0 -> err=4'b0010 on cycle 10 of the wait, sequence continues to PAUSED; err_clr pulse -> err=0.
- pause_req drops while waiting on channel 2 -> channel 2 completes its ack, then release order 2,1,0, ending in RUNNING with pause_ack=0.
- timeout=0 with ack withheld for 1000 cycles -> no err, busy=1 throughout; ack arrives -> sequence advances the next cycle.
- With ADAM_PAUSE_SEQ_DELAY_EN and settle=3 -> 3 idle cycles between consecutive ch_req rises when acks are immediate.
